wb_initiator: RTL and testbench

Fabric-side Wishbone classic initiator for the EOS S3 FPGA fabric. It turns a simple valid/ready command stream into single Wishbone read or write cycles towards fabric register blocks. Those blocks are the same kind of responder that sits behind the M4 `WBs_*` port. It returns read data or a timeout error on a valid/ready response stream. It is used for fabric-internal register sequencing and as the bus driver in responder benches.

---
 rtl/wb_initiator.sv | 109 ++++++++++
 tb/tb_wb_initiator.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_initiator.sv
// Wishbone classic initiator: one command in, one bus cycle, one response.
// Ports: clk/rst_n, cmd valid/ready stream, rsp valid/ready stream, o_wb_*/i_wb_* bus, o_timeouts.
module wb_initiator #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic        i_cmd_we,
  input  logic [16:0] i_cmd_adr,
  input  logic [31:0] i_cmd_dat,
  input  logic [3:0]  i_cmd_sel,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_dat,
  output logic        o_rsp_err,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [16:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_ack,
  output logic [7:0]  o_timeouts
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam bit             TO_EN   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [1:0]      state;
  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      o_cmd_ready <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_rsp_dat   <= '0;
      o_rsp_err   <= 1'b0;
      o_wb_cyc    <= 1'b0;
      o_wb_stb    <= 1'b0;
      o_wb_we     <= 1'b0;
      o_wb_adr    <= '0;
      o_wb_dat    <= '0;
      o_wb_sel    <= '0;
      o_timeouts  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          // ready is registered, so it only rises one edge after reset
          if (i_cmd_valid && o_cmd_ready) begin
            o_wb_we     <= i_cmd_we;
            o_wb_adr    <= i_cmd_adr;
            o_wb_dat    <= i_cmd_dat;
            o_wb_sel    <= i_cmd_sel;
            o_wb_cyc    <= 1'b1;
            o_wb_stb    <= 1'b1;
            cnt         <= '0;
            o_cmd_ready <= 1'b0;
            state       <= BUS;
          end else begin
            o_cmd_ready <= 1'b1;
          end
        end
        BUS: begin
          // ack takes priority over a timeout on the same edge
          if (i_wb_ack) begin
            o_rsp_dat   <= o_wb_we ? 32'h0 : i_wb_dat;
            o_rsp_err   <= 1'b0;
            o_wb_cyc    <= 1'b0;
            o_wb_stb    <= 1'b0;
            o_rsp_valid <= 1'b1;
            state       <= RESP;
          end else if (TO_EN && cnt == TO_LAST) begin
            o_rsp_dat   <= 32'hDEADBEEF;
            o_rsp_err   <= 1'b1;
            o_wb_cyc    <= 1'b0;
            o_wb_stb    <= 1'b0;
            o_rsp_valid <= 1'b1;
            if (o_timeouts != 8'hFF)
              o_timeouts <= o_timeouts + 8'd1;
            state       <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            o_cmd_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_initiator.sv
// Directed bench for wb_initiator (TIMEOUT=4): write, read, stale ack,
// timeout, ack-on-timeout, backpressure, saturation and async reset.
module tb_wb_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [16:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic        wb_cyc, wb_stb, wb_we, wb_ack;
  logic [16:0] wb_adr;
  logic [31:0] wb_dato, wb_dati;
  logic [3:0]  wb_sel;
  logic [7:0]  timeouts;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_initiator #(.TIMEOUT(4), .TO_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_cmd_valid(cmd_valid),
    .o_cmd_ready(cmd_ready),
    .i_cmd_we(cmd_we),
    .i_cmd_adr(cmd_adr),
    .i_cmd_dat(cmd_dat),
    .i_cmd_sel(cmd_sel),
    .o_rsp_valid(rsp_valid),
    .i_rsp_ready(rsp_ready),
    .o_rsp_dat(rsp_dat),
    .o_rsp_err(rsp_err),
    .o_wb_cyc(wb_cyc),
    .o_wb_stb(wb_stb),
    .o_wb_we(wb_we),
    .o_wb_adr(wb_adr),
    .o_wb_dat(wb_dato),
    .o_wb_sel(wb_sel),
    .i_wb_dat(wb_dati),
    .i_wb_ack(wb_ack),
    .o_timeouts(timeouts)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [16:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = a;
    cmd_dat   = d;
    cmd_sel   = s;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; cmd_valid = 0; cmd_we = 0; cmd_adr = '0;
    cmd_dat = '0; cmd_sel = '0; rsp_ready = 1'b1;
    wb_ack = 1'b0; wb_dati = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_cyc", 32'(wb_cyc), 0);
    chk("rst_ready", 32'(cmd_ready), 0);
    chk("rst_rspv", 32'(rsp_valid), 0);
    chk("rst_adr", 32'(wb_adr), 0);
    chk("rst_to", 32'(timeouts), 0);
    step();
    step();
    rst_n = 1'b1;
    #1 chk("rel_ready0", 32'(cmd_ready), 0);
    step();
    chk("rel_ready1", 32'(cmd_ready), 1);

    // write, registered-ack responder
    issue(1'b1, 17'h4, 32'h00001000, 4'hF);
    chk("wr_cyc_e0", 32'(wb_cyc), 1);
    chk("wr_stb_e0", 32'(wb_stb), 1);
    chk("wr_we_e0", 32'(wb_we), 1);
    chk("wr_adr", 32'(wb_adr), 32'h4);
    chk("wr_dat", wb_dato, 32'h00001000);
    chk("wr_sel", 32'(wb_sel), 32'hF);
    chk("wr_ready_bus", 32'(cmd_ready), 0);
    step();
    chk("wr_cyc_e1", 32'(wb_cyc), 1);
    chk("wr_rspv_e1", 32'(rsp_valid), 0);
    wb_ack = 1'b1;
    wb_dati = 32'hFFFF0000;
    step();
    wb_ack = 1'b0;
    chk("wr_cyc_e2", 32'(wb_cyc), 0);
    chk("wr_rspv_e2", 32'(rsp_valid), 1);
    chk("wr_rsp_dat", rsp_dat, 0);
    chk("wr_rsp_err", 32'(rsp_err), 0);
    chk("wr_adr_hold", 32'(wb_adr), 32'h4);
    step();
    chk("wr_rspv_e3", 32'(rsp_valid), 0);
    chk("wr_ready_e3", 32'(cmd_ready), 1);

    // read, then stale ack held through RESP and IDLE
    issue(1'b0, 17'h8, 32'h0, 4'hF);
    chk("rd_we", 32'(wb_we), 0);
    wb_ack = 1'b1;
    wb_dati = 32'h12345678;
    step();
    chk("rd_rsp_dat", rsp_dat, 32'h12345678);
    chk("rd_rsp_err", 32'(rsp_err), 0);
    step();
    chk("stale_rspv", 32'(rsp_valid), 0);
    step();
    chk("stale_cyc", 32'(wb_cyc), 0);
    chk("stale_rspv2", 32'(rsp_valid), 0);
    chk("stale_ready", 32'(cmd_ready), 1);
    wb_ack = 1'b0;
    issue(1'b0, 17'hC, 32'h0, 4'h3);
    chk("rd2_cyc", 32'(wb_cyc), 1);
    chk("rd2_sel", 32'(wb_sel), 32'h3);
    wb_ack = 1'b1;
    wb_dati = 32'hCAFEF00D;
    step();
    wb_ack = 1'b0;
    chk("rd2_rsp_dat", rsp_dat, 32'hCAFEF00D);
    chk("rd2_rspv", 32'(rsp_valid), 1);
    step();

    // timeout: cyc high for exactly 4 cycles
    issue(1'b0, 17'h10, 32'h0, 4'hF);
    for (int i = 0; i < 3; i++) begin
      chk("to_cyc_hi", 32'(wb_cyc), 1);
      step();
    end
    chk("to_cyc_hi_last", 32'(wb_cyc), 1);
    chk("to_rspv_pre", 32'(rsp_valid), 0);
    step();
    chk("to_cyc_lo", 32'(wb_cyc), 0);
    chk("to_rspv", 32'(rsp_valid), 1);
    chk("to_dat", rsp_dat, 32'hDEADBEEF);
    chk("to_err", 32'(rsp_err), 1);
    chk("to_cnt1", 32'(timeouts), 1);
    step();

    // ack on the timeout edge wins
    issue(1'b0, 17'h14, 32'h0, 4'hF);
    step();
    step();
    step();
    wb_ack = 1'b1;
    wb_dati = 32'hA5A5A5A5;
    step();
    wb_ack = 1'b0;
    chk("ackto_rspv", 32'(rsp_valid), 1);
    chk("ackto_err", 32'(rsp_err), 0);
    chk("ackto_dat", rsp_dat, 32'hA5A5A5A5);
    chk("ackto_cnt", 32'(timeouts), 1);
    step();

    // backpressure: response held, new command refused
    rsp_ready = 1'b0;
    issue(1'b0, 17'h18, 32'h0, 4'hF);
    wb_ack = 1'b1;
    wb_dati = 32'h0BADF00D;
    step();
    wb_ack = 1'b0;
    cmd_valid = 1'b1;
    cmd_we = 1'b1;
    cmd_adr = 17'h1FF;
    for (int i = 0; i < 10; i++) begin
      chk("bp_rspv", 32'(rsp_valid), 1);
      chk("bp_dat", rsp_dat, 32'h0BADF00D);
      chk("bp_err", 32'(rsp_err), 0);
      chk("bp_ready", 32'(cmd_ready), 0);
      chk("bp_cyc", 32'(wb_cyc), 0);
      step();
    end
    cmd_valid = 1'b0;
    chk("bp_adr_kept", 32'(wb_adr), 32'h18);
    rsp_ready = 1'b1;
    step();
    chk("bp_rspv_done", 32'(rsp_valid), 0);
    chk("bp_ready_done", 32'(cmd_ready), 1);

    // 300 more timeouts saturate the counter
    for (int n = 0; n < 300; n++) begin
      issue(1'b0, 17'h20, 32'h0, 4'hF);
      for (int i = 0; i < 4; i++) step();
      step();
    end
    chk("to_sat", 32'(timeouts), 255);

    // reset in the middle of a bus cycle
    issue(1'b1, 17'h30, 32'h11111111, 4'hF);
    chk("mid_cyc", 32'(wb_cyc), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_cyc", 32'(wb_cyc), 0);
    chk("mid_rst_stb", 32'(wb_stb), 0);
    chk("mid_rst_rspv", 32'(rsp_valid), 0);
    chk("mid_rst_ready", 32'(cmd_ready), 0);
    chk("mid_rst_to", 32'(timeouts), 0);
    wb_ack = 1'b1;
    step();
    rst_n = 1'b1;
    #1 chk("mid_rel_ready0", 32'(cmd_ready), 0);
    step();
    chk("mid_rel_ready1", 32'(cmd_ready), 1);
    for (int i = 0; i < 6; i++) begin
      chk("mid_no_rsp", 32'(rsp_valid), 0);
      chk("mid_no_cyc", 32'(wb_cyc), 0);
      step();
    end
    wb_ack = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
